// File: rtl/pipeline_controller.sv
// Scoreboard-based hazard, stall and flush controller for the in-order core.
// Tracks in-flight destinations, stalls ID on RAW hazards, squashes on taken branches.
module pipeline_controller #(
    parameter int NUM_STAGES       = 5,
    parameter int REG_ADDR_WIDTH   = 5,
    parameter int FORWARD_EN       = 0,
    parameter int LOAD_READY_STAGE = 4,
    parameter int BRANCH_STAGE     = 3,
    localparam int SW              = $clog2(NUM_STAGES)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs1_address,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs2_address,
    input  logic                      id_rs1_used,
    input  logic                      id_rs2_used,
    input  logic [REG_ADDR_WIDTH-1:0] id_rd_address,
    input  logic                      id_reg_wren,
    input  logic                      id_is_load,
    input  logic                      branch_taken,
    input  logic                      mem_stall,
    output logic                      pc_wren,
    output logic [NUM_STAGES-2:0]     stage_wren,
    output logic [NUM_STAGES-2:0]     stage_bubble,
    output logic [NUM_STAGES-1:0]     stage_valid,
    output logic                      reg_wren,
    output logic [SW-1:0]             fwd_rs1_sel,
    output logic [SW-1:0]             fwd_rs2_sel,
    output logic [31:0]               stall_count,
    output logic [31:0]               flush_count,
    output logic [31:0]               retired_count
);

    typedef struct packed {
        logic                      valid;
        logic [REG_ADDR_WIDTH-1:0] rd;
        logic                      wren;
        logic                      is_load;
        logic [REG_ADDR_WIDTH-1:0] rs1;
        logic [REG_ADDR_WIDTH-1:0] rs2;
        logic                      rs1_used;
        logic                      rs2_used;
    } entry_t;

    entry_t sb       [1:NUM_STAGES-1];
    entry_t shift_in [0:NUM_STAGES-2];

    logic hazard;
    logic take_branch;
    logic take_stall;
    logic retire;

    function automatic logic is_producer(input entry_t e);
        return e.valid && e.wren && (e.rd != '0);
    endfunction

    function automatic int ready_stage(input logic is_load);
        return is_load ? LOAD_READY_STAGE : 3;
    endfunction

    // A producer blocks ID unless forwarding can deliver its result in time;
    // the WB producer always blocks because the register file has no write-through.
    always_comb begin
        hazard = 1'b0;
        for (int s = 2; s < NUM_STAGES; s++) begin
            if (is_producer(sb[s]) &&
                ((id_rs1_used && id_rs1_address == sb[s].rd) ||
                 (id_rs2_used && id_rs2_address == sb[s].rd))) begin
                if (FORWARD_EN == 0 || s == NUM_STAGES - 1 ||
                    s + 1 < ready_stage(sb[s].is_load)) begin
                    hazard = 1'b1;
                end
            end
        end
        hazard = hazard & sb[1].valid;
    end

    // Scan oldest to youngest so the youngest ready producer wins.
    always_comb begin
        fwd_rs1_sel = '0;
        fwd_rs2_sel = '0;
        if (FORWARD_EN != 0 && sb[2].valid) begin
            for (int s = NUM_STAGES - 1; s >= 3; s--) begin
                if (is_producer(sb[s]) && s >= ready_stage(sb[s].is_load)) begin
                    if (sb[2].rs1_used && sb[2].rs1 != '0 && sb[2].rs1 == sb[s].rd)
                        fwd_rs1_sel = SW'(s);
                    if (sb[2].rs2_used && sb[2].rs2 != '0 && sb[2].rs2 == sb[s].rd)
                        fwd_rs2_sel = SW'(s);
                end
            end
        end
    end

    always_comb begin
        pc_wren      = 1'b1;
        stage_wren   = '1;
        stage_bubble = '0;
        take_branch  = 1'b0;
        take_stall   = 1'b0;
        if (reset) begin
            pc_wren      = 1'b0;
            stage_bubble = '1;
        end else if (mem_stall) begin
            pc_wren    = 1'b0;
            stage_wren = '0;
        end else if (branch_taken && sb[BRANCH_STAGE].valid) begin
            take_branch                       = 1'b1;
            stage_bubble[BRANCH_STAGE-1:0]    = '1;
        end else if (hazard) begin
            take_stall      = 1'b1;
            pc_wren         = 1'b0;
            stage_wren[0]   = 1'b0;
            stage_bubble[1] = 1'b1;
        end
    end

    always_comb begin
        stage_valid[0] = ~reset;
        for (int k = 1; k < NUM_STAGES; k++) begin
            stage_valid[k] = sb[k].valid;
        end
    end

    assign retire   = sb[NUM_STAGES-1].valid & ~mem_stall & ~reset;
    assign reg_wren = retire & sb[NUM_STAGES-1].wren;

    // The decoded fields of the ID instruction are captured as it moves into EX.
    always_comb begin
        for (int k = 0; k < NUM_STAGES - 1; k++) begin
            shift_in[k] = '0;
        end
        shift_in[0].valid    = stage_valid[0];
        shift_in[1].valid    = sb[1].valid;
        shift_in[1].rd       = id_rd_address;
        shift_in[1].wren     = id_reg_wren;
        shift_in[1].is_load  = id_is_load;
        shift_in[1].rs1      = id_rs1_address;
        shift_in[1].rs2      = id_rs2_address;
        shift_in[1].rs1_used = id_rs1_used;
        shift_in[1].rs2_used = id_rs2_used;
        for (int k = 2; k < NUM_STAGES - 1; k++) begin
            shift_in[k] = sb[k];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 1; k < NUM_STAGES; k++) begin
                sb[k] <= '0;
            end
            stall_count   <= '0;
            flush_count   <= '0;
            retired_count <= '0;
        end else begin
            for (int k = 0; k < NUM_STAGES - 1; k++) begin
                if (stage_wren[k]) begin
                    sb[k+1] <= stage_bubble[k] ? '0 : shift_in[k];
                end
            end
            if (take_stall)
                stall_count <= stall_count + 32'd1;
            if (take_branch)
                flush_count <= flush_count + 32'd1;
            if (retire)
                retired_count <= retired_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_pipeline_controller.sv
// Directed bench for pipeline_controller: one stall-only and one forwarding
// instance share stimulus; each table row names the instance it checks.
module tb_pipeline_controller;

    typedef struct packed {
        logic [4:0] rs1;
        logic       u1;
        logic [4:0] rs2;
        logic       u2;
        logic [4:0] rd;
        logic       wr;
        logic       ld;
    } inst_t;

    typedef struct {
        logic       dsel;
        logic       full;
        logic       rst;
        logic       br;
        logic       ms;
        inst_t      id;
        logic       pc;
        logic [3:0] wen;
        logic [3:0] bub;
        logic [4:0] vld;
        logic       rw;
        logic [2:0] f1;
        logic [2:0] f2;
        int         st;
        int         fl;
        int         rt;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [4:0] id_rs1_address, id_rs2_address, id_rd_address;
    logic       id_rs1_used, id_rs2_used, id_reg_wren, id_is_load;
    logic       branch_taken, mem_stall;

    logic       pc_wren_s, pc_wren_f, reg_wren_s, reg_wren_f;
    logic [3:0] stage_wren_s, stage_wren_f, stage_bubble_s, stage_bubble_f;
    logic [4:0] stage_valid_s, stage_valid_f;
    logic [2:0] fwd_rs1_sel_s, fwd_rs2_sel_s, fwd_rs1_sel_f, fwd_rs2_sel_f;
    logic [31:0] stall_count_s, flush_count_s, retired_count_s;
    logic [31:0] stall_count_f, flush_count_f, retired_count_f;

    int total_checks = 0;
    int passed_checks = 0;
    vec_t tbl[$];

    pipeline_controller #(.FORWARD_EN(0)) dut_stall (
        .clk(clk), .reset(reset),
        .id_rs1_address(id_rs1_address), .id_rs2_address(id_rs2_address),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_rd_address(id_rd_address), .id_reg_wren(id_reg_wren), .id_is_load(id_is_load),
        .branch_taken(branch_taken), .mem_stall(mem_stall),
        .pc_wren(pc_wren_s), .stage_wren(stage_wren_s), .stage_bubble(stage_bubble_s),
        .stage_valid(stage_valid_s), .reg_wren(reg_wren_s),
        .fwd_rs1_sel(fwd_rs1_sel_s), .fwd_rs2_sel(fwd_rs2_sel_s),
        .stall_count(stall_count_s), .flush_count(flush_count_s), .retired_count(retired_count_s)
    );

    pipeline_controller #(.FORWARD_EN(1)) dut_fwd (
        .clk(clk), .reset(reset),
        .id_rs1_address(id_rs1_address), .id_rs2_address(id_rs2_address),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_rd_address(id_rd_address), .id_reg_wren(id_reg_wren), .id_is_load(id_is_load),
        .branch_taken(branch_taken), .mem_stall(mem_stall),
        .pc_wren(pc_wren_f), .stage_wren(stage_wren_f), .stage_bubble(stage_bubble_f),
        .stage_valid(stage_valid_f), .reg_wren(reg_wren_f),
        .fwd_rs1_sel(fwd_rs1_sel_f), .fwd_rs2_sel(fwd_rs2_sel_f),
        .stall_count(stall_count_f), .flush_count(flush_count_f), .retired_count(retired_count_f)
    );

    function automatic inst_t ins(input logic [4:0] a, input logic ua, input logic [4:0] b,
                                  input logic ub, input logic [4:0] d, input logic w, input logic l);
        inst_t r;
        r = '{rs1: a, u1: ua, rs2: b, u2: ub, rd: d, wr: w, ld: l};
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_checks++;
        if (act !== exp)
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        else
            passed_checks++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic addrow(input logic dsel, input logic full, input logic rst, input logic br,
                          input logic ms, input inst_t id, input logic pc, input logic [3:0] wen,
                          input logic [3:0] bub, input logic [4:0] vld, input logic rw,
                          input logic [2:0] f1, input logic [2:0] f2,
                          input int st, input int fl, input int rt);
        vec_t v;
        v = '{dsel, full, rst, br, ms, id, pc, wen, bub, vld, rw, f1, f2, st, fl, rt};
        tbl.push_back(v);
    endtask

    // Normal-flow row: PC and every register advance, no bubbles, selects zero.
    task automatic row_n(input logic dsel, input logic br, input inst_t id, input logic [4:0] vld,
                         input logic rw, input int st, input int fl, input int rt);
        addrow(dsel, 1'b1, 1'b0, br, 1'b0, id, 1'b1, 4'hF, 4'h0, vld, rw, 3'd0, 3'd0, st, fl, rt);
    endtask

    task automatic row_r(input logic dsel);
        addrow(dsel, 1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0, 4'hF, 4'hF, 5'b0, 1'b0, 3'd0, 3'd0, 0, 0, 0);
    endtask

    task automatic applyStimulus(input vec_t v);
        reset          = v.rst;
        branch_taken   = v.br;
        mem_stall      = v.ms;
        id_rs1_address = v.id.rs1;
        id_rs1_used    = v.id.u1;
        id_rs2_address = v.id.rs2;
        id_rs2_used    = v.id.u2;
        id_rd_address  = v.id.rd;
        id_reg_wren    = v.id.wr;
        id_is_load     = v.id.ld;
    endtask

    task automatic checkOutput(input vec_t v, input int idx);
        string p;
        p = $sformatf("row%0d", idx);
        chk({p, " pc_wren"},  v.dsel ? 32'(pc_wren_f)      : 32'(pc_wren_s),      32'(v.pc));
        chk({p, " stage_wren"}, v.dsel ? 32'(stage_wren_f) : 32'(stage_wren_s),   32'(v.wen));
        chk({p, " stage_bubble"}, v.dsel ? 32'(stage_bubble_f) : 32'(stage_bubble_s), 32'(v.bub));
        chk({p, " reg_wren"}, v.dsel ? 32'(reg_wren_f)     : 32'(reg_wren_s),     32'(v.rw));
        if (v.full) begin
            chk({p, " stage_valid"}, v.dsel ? 32'(stage_valid_f) : 32'(stage_valid_s), 32'(v.vld));
            chk({p, " fwd_rs1_sel"}, v.dsel ? 32'(fwd_rs1_sel_f) : 32'(fwd_rs1_sel_s), 32'(v.f1));
            chk({p, " fwd_rs2_sel"}, v.dsel ? 32'(fwd_rs2_sel_f) : 32'(fwd_rs2_sel_s), 32'(v.f2));
            chk({p, " stall_count"}, v.dsel ? stall_count_f : stall_count_s, 32'(v.st));
            chk({p, " flush_count"}, v.dsel ? flush_count_f : flush_count_s, 32'(v.fl));
            chk({p, " retired_count"}, v.dsel ? retired_count_f : retired_count_s, 32'(v.rt));
        end
    endtask

    initial begin
        inst_t nop, addi1, add2_11, lw1, add2_10, addi0, add3_00, addi5, addi7;
        int cycles;
        vec_t v;

        nop     = '0;
        addi1   = ins(5'd0, 1'b1, 5'd0, 1'b0, 5'd1, 1'b1, 1'b0);
        add2_11 = ins(5'd1, 1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 1'b0);
        lw1     = ins(5'd0, 1'b1, 5'd0, 1'b0, 5'd1, 1'b1, 1'b1);
        add2_10 = ins(5'd1, 1'b1, 5'd0, 1'b1, 5'd2, 1'b1, 1'b0);
        addi0   = ins(5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);
        add3_00 = ins(5'd0, 1'b1, 5'd0, 1'b1, 5'd3, 1'b1, 1'b0);
        addi5   = ins(5'd0, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
        addi7   = ins(5'd0, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0);

        // Stall-only RAW: addi x1; add x2,x1,x1 -> three ID stalls with EX bubbles.
        addrow(0, 1, 1, 0, 0, nop, 0, 4'hF, 4'hF, 5'b00000, 0, 0, 0, 0, 0, 0);
        row_n(0, 0, nop,     5'b00001, 0, 0, 0, 0);
        row_n(0, 0, addi1,   5'b00011, 0, 0, 0, 0);
        addrow(0, 1, 0, 0, 0, add2_11, 0, 4'hE, 4'h2, 5'b00111, 0, 0, 0, 0, 0, 0);
        addrow(0, 1, 0, 0, 0, add2_11, 0, 4'hE, 4'h2, 5'b01011, 0, 0, 0, 1, 0, 0);
        addrow(0, 1, 0, 0, 0, add2_11, 0, 4'hE, 4'h2, 5'b10011, 1, 0, 0, 2, 0, 0);
        row_n(0, 0, add2_11, 5'b00011, 0, 3, 0, 1);
        row_n(0, 0, nop,     5'b00111, 0, 3, 0, 1);
        row_n(0, 0, nop,     5'b01111, 0, 3, 0, 1);
        row_n(0, 0, nop,     5'b11111, 1, 3, 0, 1);

        // Forwarding: same pair, no stall, EX selects stage 3 for both sources.
        row_r(1);
        addrow(1, 1, 1, 0, 0, nop, 0, 4'hF, 4'hF, 5'b00000, 0, 0, 0, 0, 0, 0);
        row_n(1, 0, nop,     5'b00001, 0, 0, 0, 0);
        row_n(1, 0, addi1,   5'b00011, 0, 0, 0, 0);
        row_n(1, 0, add2_11, 5'b00111, 0, 0, 0, 0);
        addrow(1, 1, 0, 0, 0, nop, 1, 4'hF, 4'h0, 5'b01111, 0, 3'd3, 3'd3, 0, 0, 0);
        row_n(1, 0, nop,     5'b11111, 1, 0, 0, 0);

        // Load-use with forwarding: one stall, then rs1 forwarded from stage 4.
        row_r(1);
        row_n(1, 0, nop,     5'b00001, 0, 0, 0, 0);
        row_n(1, 0, lw1,     5'b00011, 0, 0, 0, 0);
        addrow(1, 1, 0, 0, 0, add2_10, 0, 4'hE, 4'h2, 5'b00111, 0, 0, 0, 0, 0, 0);
        row_n(1, 0, add2_10, 5'b01011, 0, 1, 0, 0);
        addrow(1, 1, 0, 0, 0, nop, 1, 4'hF, 4'h0, 5'b10111, 1, 3'd4, 3'd0, 1, 0, 0);

        // x0 producer and consumer: no stall, selects stay zero.
        row_r(1);
        row_n(1, 0, nop,     5'b00001, 0, 0, 0, 0);
        row_n(1, 0, addi0,   5'b00011, 0, 0, 0, 0);
        row_n(1, 0, add3_00, 5'b00111, 0, 0, 0, 0);
        row_n(1, 0, nop,     5'b01111, 0, 0, 0, 0);

        // Taken branch with stage 3 valid, then a pulse with stage 3 invalid.
        row_r(0);
        row_n(0, 0, nop, 5'b00001, 0, 0, 0, 0);
        row_n(0, 0, nop, 5'b00011, 0, 0, 0, 0);
        row_n(0, 0, nop, 5'b00111, 0, 0, 0, 0);
        addrow(0, 1, 0, 1, 0, nop, 1, 4'hF, 4'h7, 5'b01111, 0, 0, 0, 0, 0, 0);
        row_n(0, 0, nop, 5'b10001, 0, 0, 1, 0);
        row_n(0, 1, nop, 5'b00011, 0, 0, 1, 1);
        row_n(0, 0, nop, 5'b00111, 0, 0, 1, 1);
        row_n(0, 0, nop, 5'b01111, 0, 0, 1, 1);

        // Hazard and branch together: branch wins, stall_count untouched.
        row_r(0);
        row_n(0, 0, nop,   5'b00001, 0, 0, 0, 0);
        row_n(0, 0, nop,   5'b00011, 0, 0, 0, 0);
        row_n(0, 0, addi1, 5'b00111, 0, 0, 0, 0);
        addrow(0, 1, 0, 1, 0, add2_11, 1, 4'hF, 4'h7, 5'b01111, 0, 0, 0, 0, 0, 0);
        row_n(0, 0, nop,   5'b10001, 0, 0, 1, 0);

        // mem_stall held 4 cycles over a writing WB, then reset mid-stream.
        row_r(0);
        row_n(0, 0, nop,   5'b00001, 0, 0, 0, 0);
        row_n(0, 0, addi5, 5'b00011, 0, 0, 0, 0);
        row_n(0, 0, addi7, 5'b00111, 0, 0, 0, 0);
        row_n(0, 0, nop,   5'b01111, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++)
            addrow(0, 1, 0, 0, 1, nop, 0, 4'h0, 4'h0, 5'b11111, 0, 0, 0, 0, 0, 0);
        row_n(0, 0, nop,   5'b11111, 1, 0, 0, 0);
        row_r(0);
        row_n(0, 0, nop,   5'b00001, 0, 0, 0, 0);

        v = '{0, 0, 1, 0, 0, '0, 0, 4'h0, 4'h0, 5'b0, 0, 0, 0, 0, 0, 0};
        applyStimulus(v);
        tick();
        tick();
        #2;
        chk("reset stage_valid stall-dut", 32'(stage_valid_s), 32'd0);
        chk("reset stage_valid fwd-dut", 32'(stage_valid_f), 32'd0);
        chk("reset pc_wren", 32'(pc_wren_s), 32'd0);
        chk("reset stall_count", stall_count_s, 32'd0);
        chk("reset retired_count", retired_count_s, 32'd0);

        for (int i = 0; i < tbl.size(); i++) begin
            tick();
            applyStimulus(tbl[i]);
            #2;
            checkOutput(tbl[i], i);
        end

        // Fresh fetch after reset reaches WB on the fourth following cycle.
        applyStimulus('{0, 0, 0, 0, 0, '0, 0, 4'h0, 4'h0, 5'b0, 0, 0, 0, 0, 0, 0});
        cycles = 0;
        while (cycles < 20) begin
            tick();
            cycles++;
            if (stage_valid_s[4] === 1'b1)
                break;
        end
        chk("fill latency to WB", 32'(cycles), 32'd4);

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
